imem_loader: RTL

- Writer-side companion to instr_mem: accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes each word into instruction memory at consecutive byte addresses starting at BASE_ADDR.
- Holds the CPU (pc, reg_file) in reset while a program is loading and releases it when the load completes.
- Sits between the host/testbench stimulus and the instr_mem write port.

---
 rtl/riscv_pkg.sv | 42 ++++
 rtl/byte_packer.sv | 63 ++++++
 rtl/imem_loader.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the small RISC-V core slice: datapath width,
// instruction memory geometry, reset vector and the program loader state
// encoding.
//
// Contents:
//   XLEN            data/address width of the core and memory ports
//   IMEM_DEPTH      instruction memory capacity in 32-bit words
//   RESET_VECTOR    byte address the core fetches from after reset
//   loader_state_t  imem_loader FSM states
//   accepts_start() true in the states where a new load may begin
//
// Optional build macro: IMEM_LOADER_CKSUM_EN adds the LD_CHK state used
// when the loader validates a trailing checksum byte.
// ---------------------------------------------------------------------------
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int IMEM_DEPTH = 256;
  localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;

  // LD_CHK only exists when the checksum trailer is part of the protocol.
  typedef enum logic [2:0] {
    LD_IDLE,
    LD_LEN_LO,
    LD_LEN_HI,
    LD_DATA,
`ifdef IMEM_LOADER_CKSUM_EN
    LD_CHK,
`endif
    LD_DONE,
    LD_ERR
  } loader_state_t;

  // A load can only be (re)started from a quiescent state; a start pulse
  // seen mid-transfer is dropped so a glitchy host cannot corrupt a load.
  function automatic logic accepts_start(input loader_state_t s);
    return (s == LD_IDLE) || (s == LD_DONE) || (s == LD_ERR);
  endfunction

endpackage

// File: rtl/byte_packer.sv
// ---------------------------------------------------------------------------
// byte_packer
// Collects a stream of bytes into little-endian 32-bit words. The first byte
// of each group of four lands in bits [7:0]. When the fourth byte arrives the
// completed word is registered and word_valid pulses for one cycle. Intended
// to be shared between the instruction and data memory loaders.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   synchronous active-high reset
//   clear       in   restart at lane 0 and drop any partial word
//   byte_valid  in   a byte is accepted this cycle
//   byte_data   in   [7:0] accepted byte
//   last_lane   out  the next accepted byte completes a word (lane 3)
//   word_valid  out  registered one-cycle pulse, word_data is new
//   word_data   out  [31:0] last completed word
// ---------------------------------------------------------------------------
module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        last_lane,
  output logic        word_valid,
  output logic [31:0] word_data
);

  logic [1:0]  lane;
  logic [23:0] partial;

  assign last_lane = (lane == 2'd3);

  // Lanes 0..2 park in the partial register; lane 3 goes straight into the
  // output word together with the parked bytes, so the word is available
  // one edge after its last byte with no extra pipeline stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane       <= 2'd0;
      partial    <= 24'd0;
      word_valid <= 1'b0;
      word_data  <= 32'd0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        lane    <= 2'd0;
        partial <= 24'd0;
      end else if (byte_valid) begin
        lane <= lane + 2'd1;
        case (lane)
          2'd0: partial[7:0]   <= byte_data;
          2'd1: partial[15:8]  <= byte_data;
          2'd2: partial[23:16] <= byte_data;
          default: begin
            word_data  <= {byte_data, partial};
            word_valid <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
// Loads a program into instruction memory from a byte stream and keeps the
// CPU in reset while doing so. Stream format (little-endian):
//   len[7:0], len[15:8], then 4*len data bytes, one 32-bit word per 4 bytes
//   (plus one checksum byte when IMEM_LOADER_CKSUM_EN is defined).
// Word n is written to BASE_ADDR + 4*n.
//
// Parameters:
//   XLEN           memory write port width
//   DEPTH          largest accepted word count
//   BASE_ADDR      byte address of the first word
//   HOLD_ON_RESET  1: cpu_rst high from reset until the first good load
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   start         pulse, begins a load from IDLE/DONE/ERR
//   in_valid      byte stream valid
//   in_ready      byte stream ready (registered)
//   in_data       [7:0] stream byte
//   mem_we        one-cycle write strobe per word
//   mem_addr      [XLEN-1:0] word-aligned write byte address
//   mem_wdata     [XLEN-1:0] assembled word
//   busy          load in progress
//   done          last load completed
//   error         last load rejected
//   cpu_rst       reset to pc and reg_file
//   words_loaded  [15:0] words written by the current or last load
//
// Optional build macro: IMEM_LOADER_CKSUM_EN. When defined, a trailing byte
// equal to the 8-bit sum of all length and data bytes must follow the data,
// otherwise the load ends in ERR.
// ---------------------------------------------------------------------------
module imem_loader
  import riscv_pkg::*;
#(
  parameter int              XLEN          = riscv_pkg::XLEN,
  parameter int              DEPTH         = IMEM_DEPTH,
  parameter logic [XLEN-1:0] BASE_ADDR     = RESET_VECTOR,
  parameter int              HOLD_ON_RESET = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [7:0]      in_data,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic            busy,
  output logic            done,
  output logic            error,
  output logic            cpu_rst,
  output logic [15:0]     words_loaded
);

  localparam logic [16:0] DEPTH_LIM = 17'(DEPTH);

  loader_state_t state;
  logic [15:0]   len_q;
  logic          xfer;
  logic          start_ok;
  logic          data_byte;
  logic          last_lane;
  logic [31:0]   packed_word;
  logic [15:0]   len_full;
  logic [15:0]   wl_next;
`ifdef IMEM_LOADER_CKSUM_EN
  logic [7:0]    sum_q;
`endif

  assign xfer      = in_valid && in_ready;
  assign start_ok  = start && accepts_start(state);
  assign data_byte = xfer && (state == LD_DATA);
  assign len_full  = {in_data, len_q[7:0]};
  assign wl_next   = words_loaded + 16'd1;

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_ok),
    .byte_valid (data_byte),
    .byte_data  (in_data),
    .last_lane  (last_lane),
    .word_valid (mem_we),
    .word_data  (packed_word)
  );

  assign mem_wdata = XLEN'(packed_word);

  // Loader FSM. Every status output is registered here, so done/busy/cpu_rst
  // and in_ready all change on the same edge that changes state. The write
  // address and word count are updated on the edge that accepts lane 3,
  // which is the same edge on which the packer registers the word, so
  // mem_addr and mem_wdata line up with the mem_we pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= LD_IDLE;
      in_ready     <= 1'b0;
      mem_addr     <= BASE_ADDR;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      cpu_rst      <= (HOLD_ON_RESET != 0);
      words_loaded <= 16'd0;
      len_q        <= 16'd0;
`ifdef IMEM_LOADER_CKSUM_EN
      sum_q        <= 8'd0;
`endif
    end else begin
      case (state)
        LD_IDLE, LD_DONE, LD_ERR: begin
          if (start) begin
            state        <= LD_LEN_LO;
            in_ready     <= 1'b1;
            busy         <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            cpu_rst      <= 1'b1;
            words_loaded <= 16'd0;
`ifdef IMEM_LOADER_CKSUM_EN
            sum_q        <= 8'd0;
`endif
          end
        end

        LD_LEN_LO: begin
          if (xfer) begin
            len_q[7:0] <= in_data;
            state      <= LD_LEN_HI;
`ifdef IMEM_LOADER_CKSUM_EN
            sum_q      <= sum_q + in_data;
`endif
          end
        end

        LD_LEN_HI: begin
          if (xfer) begin
            len_q[15:8] <= in_data;
`ifdef IMEM_LOADER_CKSUM_EN
            sum_q       <= sum_q + in_data;
`endif
            if (len_full == 16'd0) begin
`ifdef IMEM_LOADER_CKSUM_EN
              state    <= LD_CHK;
`else
              state    <= LD_DONE;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              cpu_rst  <= 1'b0;
`endif
            end else if ({1'b0, len_full} > DEPTH_LIM) begin
              state    <= LD_ERR;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              error    <= 1'b1;
              cpu_rst  <= 1'b1;
            end else begin
              state <= LD_DATA;
            end
          end
        end

        LD_DATA: begin
          if (xfer) begin
`ifdef IMEM_LOADER_CKSUM_EN
            sum_q <= sum_q + in_data;
`endif
            if (last_lane) begin
              mem_addr     <= BASE_ADDR + XLEN'({words_loaded, 2'b00});
              words_loaded <= wl_next;
              if (wl_next == len_q) begin
`ifdef IMEM_LOADER_CKSUM_EN
                state    <= LD_CHK;
`else
                state    <= LD_DONE;
                in_ready <= 1'b0;
                busy     <= 1'b0;
                done     <= 1'b1;
                cpu_rst  <= 1'b0;
`endif
              end
            end
          end
        end

`ifdef IMEM_LOADER_CKSUM_EN
        // The checksum byte only decides the final state; the words are
        // already in memory, so a mismatch leaves the CPU held in reset.
        LD_CHK: begin
          if (xfer) begin
            in_ready <= 1'b0;
            busy     <= 1'b0;
            if (in_data == sum_q) begin
              state   <= LD_DONE;
              done    <= 1'b1;
              cpu_rst <= 1'b0;
            end else begin
              state   <= LD_ERR;
              error   <= 1'b1;
              cpu_rst <= 1'b1;
            end
          end
        end
`endif

        default: begin
          state    <= LD_IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
